// File: rtl/eeprom_req_arb.sv
// Round-robin sequencer sharing the iic_com byte engine between requesters A and B,
// enforcing the post-write tWR idle time. Optional watchdog: define EEPROM_ARB_WATCHDOG_EN.
module eeprom_req_arb #(
    parameter int unsigned TWR_CYCLES     = 250000
`ifdef EEPROM_ARB_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       we_a,
    input  logic [7:0] addr_a,
    input  logic [7:0] wdata_a,
    output logic       ack_a,
    output logic [7:0] rdata_a,
    output logic       err_a,
    input  logic       req_b,
    input  logic       we_b,
    input  logic [7:0] addr_b,
    input  logic [7:0] wdata_b,
    output logic       ack_b,
    output logic [7:0] rdata_b,
    output logic       err_b,
    output logic [1:0] start_sig,
    output logic [7:0] addr_sig,
    output logic [7:0] wrdata,
    input  logic [7:0] rddata,
    input  logic       done_sig,
    output logic       iic_rst_n,
    output logic       busy
);

    localparam int unsigned TWR_W = 18;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_TWR} state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;     // last/current owner: 0 = A, 1 = B
    logic               we_q, we_d;
    logic [1:0]         start_q, start_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic [7:0]         rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic [TWR_W-1:0]   twr_cnt_q, twr_cnt_d;
    logic               busy_q, busy_d;
    logic               pick_b;
    logic               pick_we;

`ifdef EEPROM_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = 21;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               err_a_q, err_a_d, err_b_q, err_b_d;
    logic               iic_rst_n_q, iic_rst_n_d;
    logic               rst_hold_q, rst_hold_d;
`endif

    // Both requesting: the one not served last wins.
    assign pick_b  = req_b & (~req_a | ~grant_q);
    assign pick_we = pick_b ? we_b : we_a;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        we_d      = we_q;
        start_d   = start_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        twr_cnt_d = twr_cnt_q;
`ifdef EEPROM_ARB_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        err_a_d     = 1'b0;
        err_b_d     = 1'b0;
        rst_hold_d  = 1'b0;
        iic_rst_n_d = ~rst_hold_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_a | req_b) begin
                    grant_d = pick_b;
                    we_d    = pick_we;
                    addr_d  = pick_b ? addr_b : addr_a;
                    wdata_d = pick_b ? wdata_b : wdata_a;
                    start_d = {~pick_we, pick_we};
                    state_d = S_RUN;
`ifdef EEPROM_ARB_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            S_RUN: begin
                if (done_sig) begin
                    start_d   = 2'b00;
                    ack_a_d   = ~grant_q;
                    ack_b_d   = grant_q;
                    twr_cnt_d = '0;
                    if (!we_q) begin
                        if (grant_q) rdata_b_d = rddata;
                        else         rdata_a_d = rddata;
                    end
                    state_d = we_q ? S_TWR : S_IDLE;
                end
`ifdef EEPROM_ARB_WATCHDOG_EN
                // Engine freezes when start drops, so an abort also resets it for two cycles.
                else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    start_d     = 2'b00;
                    err_a_d     = ~grant_q;
                    err_b_d     = grant_q;
                    iic_rst_n_d = 1'b0;
                    rst_hold_d  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            S_TWR: begin
                if (twr_cnt_q == TWR_W'(TWR_CYCLES - 1)) state_d = S_IDLE;
                else                                     twr_cnt_d = twr_cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b1;
            we_q      <= 1'b0;
            start_q   <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            twr_cnt_q <= '0;
            busy_q    <= 1'b0;
`ifdef EEPROM_ARB_WATCHDOG_EN
            wd_cnt_q    <= '0;
            err_a_q     <= 1'b0;
            err_b_q     <= 1'b0;
            iic_rst_n_q <= 1'b1;
            rst_hold_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            start_q   <= start_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            twr_cnt_q <= twr_cnt_d;
            busy_q    <= busy_d;
`ifdef EEPROM_ARB_WATCHDOG_EN
            wd_cnt_q    <= wd_cnt_d;
            err_a_q     <= err_a_d;
            err_b_q     <= err_b_d;
            iic_rst_n_q <= iic_rst_n_d;
            rst_hold_q  <= rst_hold_d;
`endif
        end
    end

    assign start_sig = start_q;
    assign addr_sig  = addr_q;
    assign wrdata    = wdata_q;
    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign busy      = busy_q;
`ifdef EEPROM_ARB_WATCHDOG_EN
    assign err_a     = err_a_q;
    assign err_b     = err_b_q;
    assign iic_rst_n = iic_rst_n_q;
`else
    assign err_a     = 1'b0;
    assign err_b     = 1'b0;
    assign iic_rst_n = 1'b1;
`endif

endmodule

// File: tb/tb_eeprom_req_arb.sv
// Scoreboard bench for eeprom_req_arb with a simple iic_com stand-in whose read data is addr ^ 8'h4A.
module tb_eeprom_req_arb;

    localparam int unsigned TWR   = 20;
    localparam int unsigned DELAY = 40;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b1;
    logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [7:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
    logic       ack_a, ack_b, err_a, err_b, iic_rst_n, busy, done_sig;
    logic [7:0] rdata_a, rdata_b, addr_sig, wrdata, rddata;
    logic [1:0] start_sig;
    logic       no_done = 1'b0;
    int         eng_cnt;

    always #5 sysclk = ~sysclk;

    eeprom_req_arb #(
        .TWR_CYCLES     (TWR)
`ifdef EEPROM_ARB_WATCHDOG_EN
        ,
        .TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .sysclk (sysclk), .rst_n (rst_n),
        .req_a (req_a), .we_a (we_a), .addr_a (addr_a), .wdata_a (wdata_a),
        .ack_a (ack_a), .rdata_a (rdata_a), .err_a (err_a),
        .req_b (req_b), .we_b (we_b), .addr_b (addr_b), .wdata_b (wdata_b),
        .ack_b (ack_b), .rdata_b (rdata_b), .err_b (err_b),
        .start_sig (start_sig), .addr_sig (addr_sig), .wrdata (wrdata),
        .rddata (rddata), .done_sig (done_sig), .iic_rst_n (iic_rst_n), .busy (busy)
    );

    // Engine stand-in: one-cycle done DELAY cycles after start is seen.
    assign rddata = addr_sig ^ 8'h4A;
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt  <= 0;
            done_sig <= 1'b0;
        end else if (!iic_rst_n) begin
            eng_cnt  <= 0;
            done_sig <= 1'b0;
        end else begin
            done_sig <= 1'b0;
            if (start_sig != 2'b00 && !done_sig) begin
                if (eng_cnt == int'(DELAY) - 1 && !no_done) begin
                    done_sig <= 1'b1;
                    eng_cnt  <= 0;
                end else begin
                    eng_cnt <= eng_cnt + 1;
                end
            end else begin
                eng_cnt <= 0;
            end
        end
    end

    typedef struct packed {
        logic [1:0] start;
        logic [7:0] addr;
        logic [7:0] wdata;
    } grant_t;

    typedef struct packed {
        logic [3:0] pulses;   // {ack_a, ack_b, err_a, err_b}
        logic [7:0] rdata_a;
        logic [7:0] rdata_b;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];
    int     n_pass  = 0;
    int     n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic exp_grant(input logic [1:0] s, input logic [7:0] a, input logic [7:0] d);
        grant_t g;
        g.start = s; g.addr = a; g.wdata = d;
        grant_q.push_back(g);
    endtask

    task automatic exp_resp(input logic [3:0] p, input logic [7:0] ra, input logic [7:0] rb);
        resp_t r;
        r.pulses = p; r.rdata_a = ra; r.rdata_b = rb;
        resp_q.push_back(r);
    endtask

    // Monitor: pops expectations on each grant and each ack/err pulse.
    logic [1:0] prev_start = 2'b00;
    grant_t     mg;
    resp_t      mr;
    always @(negedge sysclk) begin
        if (prev_start == 2'b00 && start_sig != 2'b00) begin
            if (grant_q.size() == 0) begin
                n_total++;
                $display("FAIL grant_unexpected: got start %b expected no grant at %0t", start_sig, $time);
            end else begin
                mg = grant_q.pop_front();
                chk("grant_start", 32'(start_sig), 32'(mg.start));
                chk("grant_addr", 32'(addr_sig), 32'(mg.addr));
                chk("grant_wrdata", 32'(wrdata), 32'(mg.wdata));
            end
        end
        if (ack_a | ack_b | err_a | err_b) begin
            if (resp_q.size() == 0) begin
                n_total++;
                $display("FAIL resp_unexpected: got pulses %b expected none at %0t",
                         {ack_a, ack_b, err_a, err_b}, $time);
            end else begin
                mr = resp_q.pop_front();
                chk("resp_pulses", 32'({ack_a, ack_b, err_a, err_b}), 32'(mr.pulses));
                chk("resp_rdata_a", 32'(rdata_a), 32'(mr.rdata_a));
                chk("resp_rdata_b", 32'(rdata_b), 32'(mr.rdata_b));
            end
        end
        prev_start = start_sig;
    end

    task automatic wait_pulse(input logic [3:0] mask, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge sysclk);
            if (({ack_a, ack_b, err_a, err_b} & mask) != 4'b0000) seen = 1'b1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL %s: got no pulse expected pulse mask %b", name, mask);
        end
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        rst_n = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("rst_start", 32'(start_sig), 32'd0);
        chk("rst_addr", 32'(addr_sig), 32'd0);
        chk("rst_wrdata", 32'(wrdata), 32'd0);
        chk("rst_pulses", 32'({ack_a, ack_b, err_a, err_b}), 32'd0);
        chk("rst_rdata", 32'({rdata_a, rdata_b}), 32'd0);
        chk("rst_iic_rst_n", 32'(iic_rst_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge sysclk);

        // A write, then tWR hold-off
        exp_grant(2'b01, 8'h10, 8'hA5);
        exp_resp(4'b1000, 8'h00, 8'h00);
        we_a = 1'b1; addr_a = 8'h10; wdata_a = 8'hA5; req_a = 1'b1;
        repeat (10) @(negedge sysclk);
        chk("t1_start_hold", 32'(start_sig), 32'd1);
        chk("t1_addr_hold", 32'(addr_sig), 32'h10);
        wait_pulse(4'b1000, "t1_ack_a");
        req_a = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            k++;
            @(negedge sysclk);
        end
        chk("t1_busy_after_ack", 32'(k), 32'(TWR));

        // B read, no tWR afterwards
        exp_grant(2'b10, 8'h10, 8'h00);
        exp_resp(4'b0100, 8'h00, 8'h5A);
        we_b = 1'b0; addr_b = 8'h10; wdata_b = 8'h00; req_b = 1'b1;
        wait_pulse(4'b0100, "t2_ack_b");
        req_b = 1'b0;
        chk("t2_no_twr_busy", 32'(busy), 32'd0);

        // Simultaneous reads from reset alternate A, B, A, B
        do_reset();
        exp_grant(2'b10, 8'h20, 8'h00); exp_resp(4'b1000, 8'h6A, 8'h00);
        exp_grant(2'b10, 8'h30, 8'h00); exp_resp(4'b0100, 8'h6A, 8'h7A);
        exp_grant(2'b10, 8'h21, 8'h00); exp_resp(4'b1000, 8'h6B, 8'h7A);
        exp_grant(2'b10, 8'h31, 8'h00); exp_resp(4'b0100, 8'h6B, 8'h7B);
        we_a = 1'b0; wdata_a = 8'h00; we_b = 1'b0; wdata_b = 8'h00;
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    addr_a = 8'h20 + 8'(i); req_a = 1'b1;
                    wait_pulse(4'b1000, "t3_ack_a");
                    req_a = 1'b0;
                    @(negedge sysclk);
                end
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    addr_b = 8'h30 + 8'(j); req_b = 1'b1;
                    wait_pulse(4'b0100, "t3_ack_b");
                    req_b = 1'b0;
                    @(negedge sysclk);
                end
            end
        join

        // B arrives during A's tWR wait
        exp_grant(2'b01, 8'h40, 8'h3C); exp_resp(4'b1000, 8'h6B, 8'h7B);
        exp_grant(2'b10, 8'h41, 8'h00); exp_resp(4'b0100, 8'h6B, 8'h0B);
        we_a = 1'b1; addr_a = 8'h40; wdata_a = 8'h3C; req_a = 1'b1;
        wait_pulse(4'b1000, "t4_ack_a");
        req_a = 1'b0;
        repeat (5) @(negedge sysclk);
        k = 5;
        we_b = 1'b0; addr_b = 8'h41; wdata_b = 8'h00; req_b = 1'b1;
        while (start_sig == 2'b00 && k < 200) begin
            @(negedge sysclk);
            k++;
        end
        chk("t4_grant_after_twr", 32'(k), 32'(TWR + 1));
        wait_pulse(4'b0100, "t4_ack_b");
        req_b = 1'b0;

        // Asynchronous reset mid-RUN
        exp_grant(2'b10, 8'h50, 8'h00);
        we_a = 1'b0; addr_a = 8'h50; wdata_a = 8'h00; req_a = 1'b1;
        repeat (10) @(negedge sysclk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_start", 32'(start_sig), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_addr", 32'(addr_sig), 32'd0);
        chk("t5_rst_rdata", 32'({rdata_a, rdata_b}), 32'd0);
        req_a = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        exp_grant(2'b10, 8'h52, 8'h00); exp_resp(4'b1000, 8'h18, 8'h00);
        addr_a = 8'h52; req_a = 1'b1;
        wait_pulse(4'b1000, "t5_ack_a");
        req_a = 1'b0;
        @(negedge sysclk);

`ifdef EEPROM_ARB_WATCHDOG_EN
        // Engine never answers: abort after 100 cycles
        no_done = 1'b1;
        exp_grant(2'b10, 8'h60, 8'h00); exp_resp(4'b0010, 8'h18, 8'h00);
        addr_a = 8'h60; req_a = 1'b1;
        @(negedge sysclk);
        k = 0;
        while (!err_a && k < 300) begin
            @(negedge sysclk);
            k++;
        end
        chk("wd_err_latency", 32'(k), 32'd100);
        chk("wd_iic_rst_0", 32'(iic_rst_n), 32'd0);
        req_a = 1'b0;
        @(negedge sysclk);
        chk("wd_iic_rst_1", 32'(iic_rst_n), 32'd0);
        @(negedge sysclk);
        chk("wd_iic_rst_rel", 32'(iic_rst_n), 32'd1);
        no_done = 1'b0;
        exp_grant(2'b10, 8'h61, 8'h00); exp_resp(4'b1000, 8'h2B, 8'h00);
        addr_a = 8'h61; req_a = 1'b1;
        wait_pulse(4'b1000, "wd_ack_a");
        req_a = 1'b0;
`endif

        repeat (5) @(negedge sysclk);
        chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
